// File: rtl/multdiv.sv
// rtl/multdiv.sv - 32-bit signed iterative multiplier (radix-2 Booth) and divider (restoring)
// Fixed 32-edge latency for every operation, one-cycle data_resultRDY pulse on completion.

module adder32 (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_cin,
  output logic [31:0] o_sum,
  output logic        o_cout
);
  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {32'd0, i_cin};
endmodule

module multdiv (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY
);
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t      r_state;
  logic [5:0]  r_count;
  logic [31:0] r_hi;   // Booth A / divide partial remainder
  logic [31:0] r_lo;   // Booth Q / divide dividend shifting into quotient
  logic        r_qm1;
  logic [31:0] r_m;    // multiplicand or divisor magnitude
  logic        r_neg, r_dz, r_ovf;
  logic [31:0] r_result;
  logic        r_exc, r_rdy;

  logic        w_start;
  logic [31:0] w_add_a, w_add_b, w_add_sum;
  logic        w_add_cin, w_add_cout;
  logic [31:0] w_neg_a, w_neg_sum;
  logic        w_neg_cout;
  logic        w_booth_add, w_booth_sub, w_booth_op, w_bsign;
  logic [31:0] w_bsum, w_bhi, w_blo;
  logic [63:0] w_prod;
  logic        w_mul_exc;
  logic [31:0] w_rem_shift, w_dhi, w_dlo, w_div_res;
  logic [31:0] w_mag_a, w_mag_b;
  logic [5:0]  w_count_nxt;

  assign w_start     = ctrl_MULT | ctrl_DIV;
  assign w_booth_add = ~r_lo[0] & r_qm1;
  assign w_booth_sub = r_lo[0] & ~r_qm1;
  assign w_booth_op  = w_booth_add | w_booth_sub;
  assign w_rem_shift = {r_hi[30:0], r_lo[31]};
  assign w_count_nxt = r_count + 6'd1;

  // The iteration adder is idle on a start edge, so it negates operand A there.
  always_comb begin
    w_add_a   = r_hi;
    w_add_b   = r_m;
    w_add_cin = 1'b0;
    if (w_start) begin
      w_add_a   = ~data_operandA;
      w_add_b   = 32'd0;
      w_add_cin = 1'b1;
    end else if (r_state == S_DIV) begin
      w_add_a   = w_rem_shift;
      w_add_b   = ~r_m;
      w_add_cin = 1'b1;
    end else if (w_booth_sub) begin
      w_add_b   = ~r_m;
      w_add_cin = 1'b1;
    end
  end

  adder32 u_iter_add (
    .i_a    (w_add_a),
    .i_b    (w_add_b),
    .i_cin  (w_add_cin),
    .o_sum  (w_add_sum),
    .o_cout (w_add_cout)
  );

  // Shift in the true 33-bit sign so multiplicand 0x80000000 does not corrupt A.
  assign w_bsum  = w_booth_op ? w_add_sum : r_hi;
  assign w_bsign = w_booth_op ? (r_hi[31] ^ w_add_b[31] ^ w_add_cout) : r_hi[31];
  assign w_bhi   = {w_bsign, w_bsum[31:1]};
  assign w_blo   = {w_bsum[0], r_lo[31:1]};
  assign w_prod  = {w_bhi, w_blo};
  assign w_mul_exc = ~((&w_prod[63:31]) | ~(|w_prod[63:31]));

  assign w_dhi = w_add_cout ? w_add_sum : w_rem_shift;
  assign w_dlo = {r_lo[30:0], w_add_cout};

  assign w_neg_a = w_start ? ~data_operandB : ~w_dlo;

  adder32 u_neg_add (
    .i_a    (w_neg_a),
    .i_b    (32'd0),
    .i_cin  (1'b1),
    .o_sum  (w_neg_sum),
    .o_cout (w_neg_cout)
  );

  assign w_mag_a   = data_operandA[31] ? w_add_sum : data_operandA;
  assign w_mag_b   = data_operandB[31] ? w_neg_sum : data_operandB;
  assign w_div_res = r_dz ? 32'd0 : (r_neg ? w_neg_sum : w_dlo);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_count  <= 6'd0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_qm1    <= 1'b0;
      r_m      <= 32'd0;
      r_neg    <= 1'b0;
      r_dz     <= 1'b0;
      r_ovf    <= 1'b0;
      r_result <= 32'd0;
      r_exc    <= 1'b0;
      r_rdy    <= 1'b0;
    end else begin
      r_rdy <= 1'b0;
      if (w_start) begin
        r_count <= 6'd0;
        r_hi    <= 32'd0;
        r_qm1   <= 1'b0;
        r_neg   <= data_operandA[31] ^ data_operandB[31];
        r_dz    <= (data_operandB == 32'd0);
        r_ovf   <= (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);
        if (ctrl_MULT) begin
          r_state <= S_MUL;
          r_lo    <= data_operandB;
          r_m     <= data_operandA;
        end else begin
          r_state <= S_DIV;
          r_lo    <= w_mag_a;
          r_m     <= w_mag_b;
        end
      end else begin
        case (r_state)
          S_MUL: begin
            r_hi    <= w_bhi;
            r_lo    <= w_blo;
            r_qm1   <= r_lo[0];
            r_count <= w_count_nxt;
            if (w_count_nxt == 6'd32) begin
              r_state  <= S_DONE;
              r_result <= w_prod[31:0];
              r_exc    <= w_mul_exc;
              r_rdy    <= 1'b1;
            end
          end
          S_DIV: begin
            r_hi    <= w_dhi;
            r_lo    <= w_dlo;
            r_count <= w_count_nxt;
            if (w_count_nxt == 6'd32) begin
              r_state  <= S_DONE;
              r_result <= w_div_res;
              r_exc    <= r_dz | r_ovf;
              r_rdy    <= 1'b1;
            end
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign data_result    = r_result;
  assign data_exception = r_exc;
  assign data_resultRDY = r_rdy;
endmodule

// File: tb/tb_multdiv.sv
// tb/tb_multdiv.sv - directed self-checking bench for multdiv
// Inputs change on the falling edge; outputs are sampled on the falling edge.

module tb_multdiv;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] data_operandA = 32'd0;
  logic [31:0] data_operandB = 32'd0;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  int n_vec = 0;
  int n_err = 0;

  multdiv dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  always #5 clock = ~clock;

  // Drives one start edge (edge 0) and measures edges until RDY; lat = -1 on timeout.
  task automatic do_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [31:0] res, output logic exc,
                       output logic rdy_after);
    @(negedge clock);
    ctrl_MULT = m; ctrl_DIV = d; data_operandA = a; data_operandB = b;
    @(negedge clock);
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (data_resultRDY) begin
        lat = k;
        break;
      end
    end
    res = data_result;
    exc = data_exception;
    @(negedge clock);
    rdy_after = data_resultRDY;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    n_vec++; if (data_result !== 32'd0) begin n_err++; $display("FAIL reset_result got=%h exp=%h", data_result, 32'd0); end
    n_vec++; if (data_exception !== 1'b0) begin n_err++; $display("FAIL reset_exc got=%b exp=0", data_exception); end
    n_vec++; if (data_resultRDY !== 1'b0) begin n_err++; $display("FAIL reset_rdy got=%b exp=0", data_resultRDY); end
    reset = 1'b0;
  endtask

  task automatic test_mult;
    int lat; logic [31:0] res; logic exc, ra;
    do_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, lat, res, exc, ra);
    n_vec++; if (lat !== 32) begin n_err++; $display("FAIL mul7x-3_lat got=%0d exp=32", lat); end
    n_vec++; if (res !== 32'hFFFF_FFEB) begin n_err++; $display("FAIL mul7x-3_res got=%h exp=ffffffeb", res); end
    n_vec++; if (exc !== 1'b0) begin n_err++; $display("FAIL mul7x-3_exc got=%b exp=0", exc); end
    n_vec++; if (ra !== 1'b0) begin n_err++; $display("FAIL mul7x-3_rdy_after got=%b exp=0", ra); end
    repeat (3) @(negedge clock);
    n_vec++; if (data_result !== 32'hFFFF_FFEB) begin n_err++; $display("FAIL mul_hold got=%h exp=ffffffeb", data_result); end
    do_op(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, lat, res, exc, ra);
    n_vec++; if (res !== 32'd0 || exc !== 1'b1) begin n_err++; $display("FAIL mul_ovf got=%h/%b exp=00000000/1", res, exc); end
    do_op(1'b1, 1'b0, 32'h8000_0000, 32'd1, lat, res, exc, ra);
    n_vec++; if (res !== 32'h8000_0000 || exc !== 1'b0) begin n_err++; $display("FAIL mul_min_x1 got=%h/%b exp=80000000/0", res, exc); end
    do_op(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, lat, res, exc, ra);
    n_vec++; if (res !== 32'h8000_0000 || exc !== 1'b1) begin n_err++; $display("FAIL mul_min_xm1 got=%h/%b exp=80000000/1", res, exc); end
    do_op(1'b1, 1'b0, 32'hFFFF_FFF6, 32'hFFFF_FFF9, lat, res, exc, ra);
    n_vec++; if (res !== 32'd70 || exc !== 1'b0) begin n_err++; $display("FAIL mul_neg_neg got=%h/%b exp=00000046/0", res, exc); end
  endtask

  task automatic test_div;
    int lat; logic [31:0] res; logic exc, ra;
    do_op(1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7, lat, res, exc, ra);
    n_vec++; if (lat !== 32) begin n_err++; $display("FAIL div_lat got=%0d exp=32", lat); end
    n_vec++; if (res !== 32'hFFFF_FFF2 || exc !== 1'b0) begin n_err++; $display("FAIL div-100/7 got=%h/%b exp=fffffff2/0", res, exc); end
    do_op(1'b0, 1'b1, 32'd5, 32'd0, lat, res, exc, ra);
    n_vec++; if (lat !== 32) begin n_err++; $display("FAIL div0_lat got=%0d exp=32", lat); end
    n_vec++; if (res !== 32'd0 || exc !== 1'b1) begin n_err++; $display("FAIL div5/0 got=%h/%b exp=00000000/1", res, exc); end
    do_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, res, exc, ra);
    n_vec++; if (res !== 32'h8000_0000 || exc !== 1'b1) begin n_err++; $display("FAIL div_min/-1 got=%h/%b exp=80000000/1", res, exc); end
    do_op(1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE, lat, res, exc, ra);
    n_vec++; if (res !== 32'hFFFF_FFFD || exc !== 1'b0) begin n_err++; $display("FAIL div7/-2 got=%h/%b exp=fffffffd/0", res, exc); end
    do_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, lat, res, exc, ra);
    n_vec++; if (res !== 32'd3 || exc !== 1'b0) begin n_err++; $display("FAIL div-7/-2 got=%h/%b exp=00000003/0", res, exc); end
    do_op(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h8000_0000, lat, res, exc, ra);
    n_vec++; if (res !== 32'd0 || exc !== 1'b0) begin n_err++; $display("FAIL div-1/min got=%h/%b exp=00000000/0", res, exc); end
  endtask

  task automatic test_reset_midop;
    int lat; logic [31:0] res; logic exc, ra;
    int seen;
    @(negedge clock);
    ctrl_MULT = 1'b1; data_operandA = 32'h0000_1234; data_operandB = 32'd5;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (data_resultRDY) seen++;
    end
    n_vec++; if (seen !== 0) begin n_err++; $display("FAIL rstmid_rdy got=%0d pulses exp=0", seen); end
    n_vec++; if (data_result !== 32'd0 || data_exception !== 1'b0) begin n_err++; $display("FAIL rstmid_out got=%h/%b exp=00000000/0", data_result, data_exception); end
    do_op(1'b0, 1'b1, 32'd100, 32'd7, lat, res, exc, ra);
    n_vec++; if (lat !== 32 || res !== 32'd14 || exc !== 1'b0) begin n_err++; $display("FAIL rstmid_div got=%0d/%h/%b exp=32/0000000e/0", lat, res, exc); end
  endtask

  task automatic test_abandon;
    int seen, at;
    logic [31:0] res;
    @(negedge clock);
    ctrl_MULT = 1'b1; data_operandA = 32'd9; data_operandB = 32'd3;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    repeat (4) @(negedge clock);
    ctrl_DIV = 1'b1;
    @(negedge clock);
    ctrl_DIV = 1'b0;
    seen = 0; at = -1; res = 32'd0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (data_resultRDY) begin
        seen++;
        at = k;
        res = data_result;
      end
    end
    n_vec++; if (seen !== 1 || at !== 32) begin n_err++; $display("FAIL abandon_rdy got=%0d pulses at %0d exp=1 at 32", seen, at); end
    n_vec++; if (res !== 32'd3) begin n_err++; $display("FAIL abandon_res got=%h exp=00000003", res); end
  endtask

  task automatic test_both;
    int lat; logic [31:0] res; logic exc, ra;
    do_op(1'b1, 1'b1, 32'd6, 32'd2, lat, res, exc, ra);
    n_vec++; if (lat !== 32 || res !== 32'd12 || exc !== 1'b0) begin n_err++; $display("FAIL both_ctrl got=%0d/%h/%b exp=32/0000000c/0", lat, res, exc); end
    repeat (5) @(negedge clock);
    n_vec++; if (data_resultRDY !== 1'b0 || data_result !== 32'd12) begin n_err++; $display("FAIL both_no_div got=%b/%h exp=0/0000000c", data_resultRDY, data_result); end
  endtask

  task automatic test_back_to_back;
    int lat; logic [31:0] res; logic exc, ra;
    do_op(1'b1, 1'b0, 32'h0000_FFFF, 32'h0000_FFFF, lat, res, exc, ra);
    n_vec++; if (res !== 32'hFFFE_0001 || exc !== 1'b1) begin n_err++; $display("FAIL b2b_mul got=%h/%b exp=fffe0001/1", res, exc); end
    do_op(1'b0, 1'b1, 32'h7FFF_FFFF, 32'd2, lat, res, exc, ra);
    n_vec++; if (lat !== 32 || res !== 32'h3FFF_FFFF || exc !== 1'b0) begin n_err++; $display("FAIL b2b_div got=%0d/%h/%b exp=32/3fffffff/0", lat, res, exc); end
  endtask

  initial begin
    test_reset;
    test_mult;
    test_div;
    test_reset_midop;
    test_abandon;
    test_both;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
